muldiv_unit: RTL
================

# muldiv_unit

Parametrised iterative multiply/divide unit with architectural HI/LO registers for the pipelined MIPS core. It replaces the single-mode multiplier driven by `start_mult`/`mult_sign` and adds unsigned/signed divide, MTHI/MTLO writes, a busy indication for hazard-unit stalls, and flush/cancel. It sits beside the ALU in the execute stage, and its HI/LO outputs feed the `out_select` result mux.

## Interface
- `WIDTH`, default 32: operand width; HI and LO are each WIDTH bits; must be ≥ 4.
- `clk`  input  1  rising-edge clock.
- `reset`  input  1  asynchronous, active-high; clears all state.
- `start`  input  1  begin an operation; sampled only in IDLE.
- `op_div`  input  1  0 = multiply, 1 = divide; sampled with `start`.
- `op_sign`  input  1  1 = signed (two's complement), 0 = unsigned; sampled with `start`.
- `a`  input  WIDTH  multiplicand or dividend; sampled with `start`.
- `b`  input  WIDTH  multiplier or divisor; sampled with `start`.
- `flush`  input  1  cancel the in-flight operation (pipeline flush).
- `hi_we`  input  1  MTHI write strobe.
- `lo_we`  input  1  MTLO write strobe.
- `wdata`  input  WIDTH  data for MTHI/MTLO.
- `busy`  output  1  high while an operation is in progress; drives the hazard-unit stall.
- `done`  output  1  one-cycle pulse after HI/LO are updated by an operation.
- `hi`  output  WIDTH  HI register: product upper half, or remainder.
- `lo`  output  WIDTH  LO register: product lower half, or quotient.

## Operation
- FSM states: IDLE, CALC, FIX.
- IDLE:
  - On `start`, latch `op_div`, `op_sign`, and the magnitudes of `a` and `b`. Magnitudes are the operands themselves when unsigned, or abs() when signed.
  - Latch the result-sign flags: negative product/quotient = `a[W-1]^b[W-1]`; negative remainder = `a[W-1]`. Both flags are 0 when unsigned.
  - Load iteration counter = WIDTH, then go to CALC.
- CALC, one iteration per cycle, counter decrements, go to FIX when the counter reaches 0:
  - Multiply is radix-2 shift-add over a 2·WIDTH accumulator.
  - Divide is restoring shift-subtract. Partial remainder is WIDTH+1 bits; the quotient shifts into the low half.
- FIX:
  - Negate the two's-complement halves per the sign flags. For multiply, the negation is across the full 2·WIDTH product.
  - Write HI/LO, then go to IDLE.
- Divide by zero (`b`==0, signed or unsigned): skip fixup; HI = original `a`, LO = all ones. Latency is unchanged.
- Signed most-negative ÷ −1: LO = most-negative value (wraps), HI = 0. This falls out naturally from magnitude arithmetic.
- MTHI/MTLO:
  - In IDLE, `hi_we`/`lo_we` write `wdata` at the edge.
  - While `busy`, writes are ignored; the controller stalls before issuing them.
- `flush`:
  - In CALC or FIX, return to IDLE at the next edge. HI/LO are unchanged and `done` stays 0.
  - In IDLE, `flush` suppresses a coincident `start`.
- `start` while `busy`: ignored.

## Timing
- Reset values: state IDLE; `busy`=0, `done`=0, `hi`=0, `lo`=0; counter and accumulator 0.
- `start` is accepted at edge E0. `busy`=1 from after E0 through edge E(WIDTH+1), i.e. WIDTH+1 cycles.
- HI/LO are updated at E(WIDTH+1).
- `done`=1 for exactly the cycle after E(WIDTH+1), with `busy`=0 in that cycle.
- Back-to-back: `start` in the `done` cycle is accepted. No dead cycle between operations.
- `start` together with `hi_we`/`lo_we` in IDLE: the write lands at E0, and the operation result overwrites it at completion.
- `busy` and `done` are registered, not combinational from `start`. The hazard unit stalls on `start` itself in the issue cycle.
- Reset mid-operation: immediate return to the reset values; no partial result is written.

## Test plan
- Unsigned multiply, WIDTH=32, a=0xFFFFFFFF, b=0xFFFFFFFF -> after 33 cycles HI=0xFFFFFFFE, LO=0x00000001; `done` pulses once.
- Signed multiply, a=−7 (0xFFFFFFF9), b=3 -> HI=0xFFFFFFFF, LO=0xFFFFFFEB.
- Signed divide, a=−7, b=2 -> LO=0xFFFFFFFD (−3), HI=0xFFFFFFFF (−1).
- Unsigned divide, a=100, b=7 -> LO=14, HI=2.
- Signed divide, a=0x80000000, b=0xFFFFFFFF -> LO=0x80000000, HI=0.
- Divide by zero, a=0x1234 -> HI=0x1234, LO=0xFFFFFFFF.
- MTHI/flush/reset behaviour:
  - MTHI 0xAAAA in IDLE -> HI=0xAAAA next cycle; a subsequent hi_we while busy leaves HI unchanged.
  - Start then flush at cycle 10 -> `busy`=0 next cycle, HI/LO unchanged, no `done`.
  - Start then reset at cycle 5 -> all outputs 0.
- Back-to-back: second `start` issued in the `done` cycle -> second `done` exactly 33 cycles later. A `start` issued while busy is ignored.

Source files
------------

// File: rtl/muldiv_unit_if.sv
// rtl/muldiv_unit_if.sv - issue/result bundle between the execute stage and the multiply/divide unit
interface muldiv_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic             op_div;
    logic             op_sign;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             flush;
    logic             hi_we;
    logic             lo_we;
    logic [WIDTH-1:0] wdata;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, op_div, op_sign, a, b, flush, hi_we, lo_we, wdata,
        input  busy, done, hi, lo
    );

    modport slave (
        input  start, op_div, op_sign, a, b, flush, hi_we, lo_we, wdata,
        output busy, done, hi, lo
    );
endinterface

// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - iterative shift-add multiply / restoring divide with architectural HI/LO
module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic      clk,
    input  logic      reset,
    muldiv_if.slave   bus
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

    state_t             state_q, state_d;
    logic               is_div;
    logic               neg_q;
    logic               neg_r;
    logic [WIDTH-1:0]   mag_b;
    logic [2*WIDTH-1:0] acc;
    logic [WIDTH-1:0]   rem;
    logic [CW-1:0]      cnt;
    logic [WIDTH-1:0]   hi_q, lo_q;
    logic               done_q;

    logic               a_neg, b_neg, div_zero;
    logic [WIDTH-1:0]   a_mag, b_mag;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_shift, div_sub;
    logic               div_ge;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo_fix, rem_fix;

    assign bus.busy = (state_q != IDLE);
    assign bus.done = done_q;
    assign bus.hi   = hi_q;
    assign bus.lo   = lo_q;

    // Divide by zero runs the raw dividend unsigned with no sign fixup, so the
    // restoring loop itself leaves HI = a and LO = all ones.
    assign div_zero = bus.op_div && (bus.b == '0);
    assign a_neg    = bus.op_sign && bus.a[WIDTH-1] && !div_zero;
    assign b_neg    = bus.op_sign && bus.b[WIDTH-1];
    assign a_mag    = a_neg ? -bus.a : bus.a;
    assign b_mag    = b_neg ? -bus.b : bus.b;

    assign mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, mag_b} : '0);
    assign div_shift = {rem, acc[WIDTH-1]};
    assign div_sub   = div_shift - {1'b0, mag_b};
    assign div_ge    = (div_shift >= {1'b0, mag_b});

    assign prod_fix = neg_q ? -acc : acc;
    assign quo_fix  = neg_q ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    assign rem_fix  = neg_r ? -rem : rem;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (bus.start && !bus.flush) state_d = CALC;
            CALC: begin
                if (bus.flush)             state_d = IDLE;
                else if (cnt == CW'(1))    state_d = FIX;
            end
            FIX:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            is_div  <= 1'b0;
            neg_q   <= 1'b0;
            neg_r   <= 1'b0;
            mag_b   <= '0;
            acc     <= '0;
            rem     <= '0;
            cnt     <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            done_q  <= (state_q == FIX) && !bus.flush;
            case (state_q)
                IDLE: begin
                    if (bus.hi_we) hi_q <= bus.wdata;
                    if (bus.lo_we) lo_q <= bus.wdata;
                    if (bus.start && !bus.flush) begin
                        is_div <= bus.op_div;
                        neg_q  <= a_neg ^ b_neg;
                        neg_r  <= a_neg;
                        mag_b  <= b_mag;
                        acc    <= {{WIDTH{1'b0}}, a_mag};
                        rem    <= '0;
                        cnt    <= CW'(WIDTH);
                    end
                end
                CALC: begin
                    cnt <= cnt - CW'(1);
                    if (is_div) begin
                        rem              <= WIDTH'(div_ge ? div_sub : div_shift);
                        acc[WIDTH-1:0]   <= {acc[WIDTH-2:0], div_ge};
                    end else begin
                        acc <= {mul_sum, acc[WIDTH-1:1]};
                    end
                end
                FIX: begin
                    if (!bus.flush) begin
                        if (is_div) begin
                            hi_q <= rem_fix;
                            lo_q <= quo_fix;
                        end else begin
                            hi_q <= prod_fix[2*WIDTH-1:WIDTH];
                            lo_q <= prod_fix[WIDTH-1:0];
                        end
                    end
                end
                default: ;
            endcase
        end
    end
endmodule
